fp_norm_round: RTL and testbench

Pipelined normalize-and-round stage of the FPU datapath, directly downstream of the adder/multiplier mantissa datapath. It consumes an unnormalized 32-bit magnitude with a working exponent. It uses the existing `lzc` leading-zero counter to left-normalize, or right-shifts once on carry-out. It then rounds to nearest-even and packs an IEEE-754 single-precision result with exception flags. The stage is two pipeline registers deep, with valid/ready handshakes on both sides.

---
 rtl/fp_norm_round_pkg.sv | 19 +
 rtl/fp_norm_round_lzc.sv | 20 ++
 rtl/fp_norm_round.sv | 138 +++++++++++++
 tb/tb_fp_norm_round.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fp_norm_round_pkg.sv
// Shared FPU normalize/round constants and the stage-1 pipeline record.
package fp_norm_round_pkg;

    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;
    localparam int MANT_W  = 23;
    localparam int EXP_W   = 8;
    localparam int WEXP_W  = 10;

    // m[30] is the hidden bit once normalized; m[6:0] feed guard/sticky.
    typedef struct packed {
        logic                     sign;
        logic                     zero;
        logic signed [WEXP_W-1:0] exp;
        logic [30:0]              mant;
        logic                     sticky;
    } s1_t;

endpackage

// File: rtl/fp_norm_round_lzc.sv
// Leading-zero counter: 32-bit input, 5-bit count, all_zeroes flag.
module lzc (
    input  logic [31:0] data_in,
    output logic [4:0]  count,
    output logic        all_zeroes
);

    always_comb begin
        count      = '0;
        all_zeroes = 1'b1;
        // Scan upward so the highest set bit wins.
        for (int i = 0; i < 32; i++) begin
            if (data_in[i]) begin
                count      = 5'(31 - i);
                all_zeroes = 1'b0;
            end
        end
    end

endmodule

// File: rtl/fp_norm_round.sv
// Two-stage normalize (lzc-driven shift) then round-to-nearest-even and
// IEEE-754 single-precision pack, with valid/ready on both sides.
module fp_norm_round
    import fp_norm_round_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [WEXP_W-1:0] in_exp,
    input  logic [31:0]       in_mant,
    input  logic              in_sticky,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_result,
    output logic              out_overflow,
    output logic              out_underflow,
    output logic              out_inexact
);

    logic        s1_valid_q, s1_valid_d;
    s1_t         s1_q, s1_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_result_q, out_result_d;
    logic        out_overflow_q, out_overflow_d;
    logic        out_underflow_q, out_underflow_d;
    logic        out_inexact_q, out_inexact_d;

    logic [4:0]  zc;
    logic        mant_zero;
    logic        adv2;

    logic                     lsb, g, s, up;
    logic [24:0]              f;
    logic [MANT_W-1:0]        frac;
    logic signed [WEXP_W-1:0] e2;

    lzc u_lzc (
        .data_in    (in_mant),
        .count      (zc),
        .all_zeroes (mant_zero)
    );

    assign adv2     = !out_valid_q | out_ready;
    assign in_ready = !s1_valid_q | adv2;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_d.sign   = in_sign;
                s1_d.zero   = 1'b0;
                s1_d.sticky = in_sticky;
                if (in_mant[31]) begin
                    s1_d.mant   = in_mant[31:1];
                    s1_d.exp    = in_exp + 10'd1;
                    s1_d.sticky = in_sticky | in_mant[0];
                end else if (mant_zero) begin
                    s1_d.zero = 1'b1;
                    s1_d.mant = '0;
                    s1_d.exp  = '0;
                end else begin
                    s1_d.mant = 31'(in_mant << (zc - 5'd1));
                    s1_d.exp  = in_exp + 10'd1 - 10'(zc);
                end
            end
        end
    end

    always_comb begin
        lsb  = s1_q.mant[7];
        g    = s1_q.mant[6];
        s    = (|s1_q.mant[5:0]) | s1_q.sticky;
        up   = g & (s | lsb);
        f    = 25'(s1_q.mant[30:7]) + 25'(up);
        // A rounding carry renormalizes right by one; the shifted-out bit is zero.
        frac = f[24] ? f[23:1] : f[22:0];
        e2   = s1_q.exp + 10'(f[24]);

        out_valid_d     = out_valid_q;
        out_result_d    = out_result_q;
        out_overflow_d  = out_overflow_q;
        out_underflow_d = out_underflow_q;
        out_inexact_d   = out_inexact_q;
        if (adv2) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_overflow_d  = 1'b0;
                out_underflow_d = 1'b0;
                if (s1_q.zero) begin
                    out_result_d  = {s1_q.sign, 31'b0};
                    out_inexact_d = 1'b0;
                end else if (e2 >= $signed(10'(EXP_MAX))) begin
                    out_result_d   = {s1_q.sign, 8'hFF, 23'b0};
                    out_overflow_d = 1'b1;
                    out_inexact_d  = 1'b1;
                end else if (e2 <= 10'sd0) begin
                    out_result_d    = {s1_q.sign, 31'b0};
                    out_underflow_d = 1'b1;
                    out_inexact_d   = 1'b1;
                end else begin
                    out_result_d  = {s1_q.sign, e2[EXP_W-1:0], frac};
                    out_inexact_d = g | s;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q      <= 1'b0;
            s1_q            <= '0;
            out_valid_q     <= 1'b0;
            out_result_q    <= '0;
            out_overflow_q  <= 1'b0;
            out_underflow_q <= 1'b0;
            out_inexact_q   <= 1'b0;
        end else begin
            s1_valid_q      <= s1_valid_d;
            s1_q            <= s1_d;
            out_valid_q     <= out_valid_d;
            out_result_q    <= out_result_d;
            out_overflow_q  <= out_overflow_d;
            out_underflow_q <= out_underflow_d;
            out_inexact_q   <= out_inexact_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_result    = out_result_q;
    assign out_overflow  = out_overflow_q;
    assign out_underflow = out_underflow_q;
    assign out_inexact   = out_inexact_q;

endmodule

// File: tb/tb_fp_norm_round.sv
// Bench for fp_norm_round: arithmetic reference model, directed vectors,
// randomized backpressure stream and mid-stream asynchronous reset.
module tb_fp_norm_round;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [9:0]  in_exp = '0;
    logic [31:0] in_mant = '0;
    logic        in_sticky = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_overflow, out_underflow, out_inexact;

    logic [34:0] dv;
    assign dv = {out_overflow, out_underflow, out_inexact, out_result};

    int n_checks = 0;
    int n_pass   = 0;
    logic [34:0] expq[$];
    logic        stall_q = 1'b0;
    logic [34:0] held = '0;

    fp_norm_round dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sign       (in_sign),
        .in_exp        (in_exp),
        .in_mant       (in_mant),
        .in_sticky     (in_sticky),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow),
        .out_inexact   (out_inexact)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, want);
    endtask

    // Value-level reference: locate the leading one, keep 24 significant
    // bits, compare the discarded remainder against one half.
    function automatic logic [34:0] model(input logic sign, input logic [9:0] ex,
                                          input logic [31:0] mant, input logic stk);
        int p, e, exv;
        longint keep, rem, half;
        logic up, inx;
        logic [7:0]  e8;
        logic [22:0] f23;
        if (mant == 32'd0) return {3'b000, sign, 31'b0};
        p = 31;
        while (mant[p] == 1'b0) p--;
        exv = int'($signed(ex));
        e = exv + p - 30;
        if (p > 23) begin
            keep = longint'(mant) >> (p - 23);
            rem  = longint'(mant) & ((longint'(1) << (p - 23)) - 1);
            half = longint'(1) << (p - 24);
            up   = (rem > half) || (rem == half && (stk || keep[0]));
            inx  = (rem != 0) || stk;
        end else begin
            keep = longint'(mant) << (23 - p);
            up   = 1'b0;
            inx  = stk;
        end
        keep = keep + longint'(up);
        if (keep >= (longint'(1) << 24)) begin
            keep = keep >> 1;
            e++;
        end
        if (e >= 255) return {3'b101, sign, 8'hFF, 23'b0};
        if (e <= 0)   return {3'b011, sign, 31'b0};
        e8  = e[7:0];
        f23 = keep[22:0];
        return {2'b00, inx, sign, e8, f23};
    endfunction

    // Compare process: samples 2 time units after each falling edge.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                expq.delete();
                stall_q = 1'b0;
            end else begin
                if (stall_q)
                    check("stall_hold", 40'({out_valid, dv}), 40'({1'b1, held}));
                if (in_valid && in_ready)
                    expq.push_back(model(in_sign, in_exp, in_mant, in_sticky));
                if (out_valid && out_ready) begin
                    if (expq.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_output: got %h expected none", dv);
                    end else begin
                        check("stream_vs_model", 40'(dv), 40'(expq.pop_front()));
                    end
                end
                stall_q = out_valid && !out_ready;
                held    = dv;
            end
        end
    end

    task automatic directed(input string nm, input logic sg, input logic [9:0] ex,
                            input logic [31:0] m, input logic stk, input logic [34:0] want);
        @(negedge clk);
        in_valid = 1'b1; in_sign = sg; in_exp = ex; in_mant = m; in_sticky = stk;
        out_ready = 1'b1;
        #2 check({nm, "_ready"}, 40'(in_ready), 40'(1));
        @(negedge clk);
        in_valid = 1'b0;
        #2 check({nm, "_lat1"}, 40'(out_valid), 40'(0));
        @(negedge clk);
        #2 check({nm, "_lat2"}, 40'({out_valid, dv}), 40'({1'b1, want}));
    endtask

    task automatic rand_operand();
        in_sign   = 1'($urandom_range(0, 1));
        in_sticky = 1'($urandom_range(0, 1));
        in_mant   = $urandom;
        if ($urandom_range(0, 3) == 0) in_mant = in_mant >> $urandom_range(0, 31);
        in_exp = 10'($urandom_range(0, 300)) - 10'd50;
    endtask

    task automatic run_stream(input int n, input int reset_at);
        int  sent = 0;
        int  cycles = 0;
        logic acc = 1'b0;
        while (sent < n && cycles < 2000) begin
            @(negedge clk);
            cycles++;
            if (acc) in_valid = 1'b0;
            acc = 1'b0;
            if (cycles == reset_at) begin
                in_valid = 1'b0;
                #3 rst_n = 1'b0;
                #1 check("async_reset",
                         40'({dut.s1_valid_q, out_valid, in_ready, dv}),
                         40'({1'b0, 1'b0, 1'b1, 35'b0}));
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                continue;
            end
            out_ready = 1'($urandom_range(0, 1));
            if (!in_valid && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                rand_operand();
            end
            #1;
            acc = in_valid && in_ready;
            if (acc) sent++;
        end
        @(negedge clk);
        if (acc) in_valid = 1'b0;
        check("stream_sent", 40'(sent), 40'(n));
    endtask

    task automatic drain();
        int k = 0;
        out_ready = 1'b1;
        while ((expq.size() != 0 || out_valid) && k < 50) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        #3 check("drain_empty", 40'({out_valid, 32'(expq.size())}), 40'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 check("reset_state", 40'({in_ready, out_valid, dv}), 40'({1'b1, 1'b0, 35'b0}));
        @(negedge clk);
        rst_n = 1'b1;

        directed("one",       1'b0, 10'd127,  32'h40000000, 1'b0, {3'b000, 32'h3F800000});
        directed("carry_out", 1'b0, 10'd127,  32'h80000000, 1'b0, {3'b000, 32'h40000000});
        directed("zc31",      1'b0, 10'd157,  32'h00000001, 1'b0, {3'b000, 32'h3F800000});
        directed("rnd_carry", 1'b0, 10'd127,  32'h7FFFFFC0, 1'b0, {3'b001, 32'h40000000});
        directed("tie_even",  1'b0, 10'd127,  32'h40000040, 1'b0, {3'b001, 32'h3F800000});
        directed("tie_odd",   1'b0, 10'd127,  32'h400000C0, 1'b0, {3'b001, 32'h3F800002});
        directed("tie_stk",   1'b0, 10'd127,  32'h40000040, 1'b1, {3'b001, 32'h3F800001});
        directed("overflow",  1'b1, 10'd255,  32'h40000000, 1'b0, {3'b101, 32'hFF800000});
        directed("rnd_ovf",   1'b0, 10'd254,  32'h7FFFFFC0, 1'b0, {3'b101, 32'h7F800000});
        directed("underflow", 1'b0, 10'd0,    32'h40000000, 1'b0, {3'b011, 32'h00000000});
        directed("neg_exp",   1'b1, 10'h3FB,  32'h00000001, 1'b0, {3'b011, 32'h80000000});
        directed("zero",      1'b1, 10'd50,   32'h00000000, 1'b1, {3'b000, 32'h80000000});
        directed("max_norm",  1'b0, 10'd254,  32'h7FFFFF80, 1'b0, {3'b000, 32'h7F7FFFFF});

        run_stream(8, 0);
        drain();
        run_stream(12, 9);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
